key_debounce_multi: RTL and testbench
=====================================

// Module: key_debounce_multi
// PURPOSE
// - N-channel successor to the single-key 5-state debouncer: parametrised sample rate, debounce depth and channel count.
// - Adds per-channel press/release/long-press event pulses and an optional auto-repeat.
// - Sits between the raw board buttons and the DDS control logic (frequency, phase, amplitude and waveform step keys).
// - Keys are active-low: 0 = pressed.
// PARAMETERS
// - N_KEYS        2      number of independent key channels
// - TICK_DIV      50000  clk cycles per sample tick (>=1; 1 = every clk; 50000 = 1 ms at 50 MHz)
// - DEB_CNT       5      consecutive identical ticks needed to accept a level change (>=1)
// - LONG_TICKS    1000   ticks held (after debounce) before key_long fires (>=1)
// - REPEAT_TICKS  200    ticks between auto-repeat press pulses (>=1; only used with KEY_REPEAT_EN)
// PORTS
// - clk          in   1       system clock
// - rst_n        in   1       asynchronous reset, active-low
// - key          in   N_KEYS  raw asynchronous key inputs, active-low
// - key_out      out  N_KEYS  debounced level, active-low (1 = released)
// - key_press    out  N_KEYS  1-clk pulse on accepted press (and each auto-repeat)
// - key_release  out  N_KEYS  1-clk pulse on accepted release
// - key_long     out  N_KEYS  1-clk pulse, once per hold, when LONG_TICKS is reached
// BEHAVIOUR
// - Reset (async, rst_n=0):
//   - key_out = all ones; key_press, key_release and key_long = 0.
//   - Synchronisers are preset to 1; prescaler, all counters and FSMs are cleared, and every channel goes to REL.
//   - Reset mid-press drops any event in flight; no release pulse is emitted.
// - Synchroniser: 2 flip-flops per channel. All decisions use the synchronised level ks.
// - Prescaler:
//   - Counts 0..TICK_DIV-1 and wraps.
//   - tick=1 for one clk while count==TICK_DIV-1. The tick is shared by all channels.
// - Per-channel FSM. Every state evaluates only on tick; the debounce counter dcnt has width $clog2(DEB_CNT+1).
//   - REL:
//     - ks=0 -> dcnt=1. If DEB_CNT==1, accept the press at once; otherwise go to PDB.
//   - PDB:
//     - ks=0 -> dcnt++. When dcnt reaches DEB_CNT, go to HELD, register key_out=0, pulse key_press, clear hcnt.
//     - ks=1 -> return to REL, dcnt=0, no outputs.
//   - HELD:
//     - ks=1 -> go to RDB, dcnt=1. If DEB_CNT==1, accept the release at once.
//     - ks=0 -> hcnt++ (saturating). On hcnt==LONG_TICKS, pulse key_long exactly once.
//   - RDB:
//     - ks=1 -> dcnt++. When dcnt reaches DEB_CNT, go to REL, key_out=1, pulse key_release, clear hcnt/rcnt.
//     - ks=0 -> return to HELD, dcnt=0. hcnt is kept (a bounce does not restart long-press timing).
// - Latency:
//   - Event pulses and the key_out change are registered one clk after the accepting tick.
//   - Input-to-output delay = 2 clk (sync) + time to DEB_CNT ticks + 1 clk.
// - Pulse width: every event pulse is exactly 1 clk. Channels are fully independent; simultaneous events on several channels are all reported in the same clk.
// - Glitch rejection: a level held for fewer than DEB_CNT consecutive ticks never changes key_out and never produces a pulse.
// - Counter widths: hcnt has width $clog2(LONG_TICKS+1) and saturates at LONG_TICKS (no wrap on very long holds).
// CONFIGURATION
// - Macro KEY_REPEAT_EN.
//   - Defined: in HELD, once key_long has fired, rcnt counts ticks. Every REPEAT_TICKS ticks, rcnt clears and key_press pulses again.
//     This continues until RDB is entered; rcnt is frozen in RDB and cleared on REL.
//   - Undefined: rcnt logic is absent and REPEAT_TICKS is ignored. key_press fires exactly once per accepted press.
// TESTING (N_KEYS=2, TICK_DIV=4, DEB_CNT=5, LONG_TICKS=20, REPEAT_TICKS=8)
// - Reset: hold rst_n=0 with key=2'b00 -> key_out=2'b11 and all pulses 0. Release reset: no pulse until 5 ticks have elapsed.
// - Clean press on key[0]: low for 40 clk -> one key_press[0] pulse 1 clk after the 5th low tick; key_out[0]=0; key[1] channel unaffected.
// - Bounce: key[0] low 3 ticks, high 1 tick, low 5 ticks -> exactly one key_press[0], after the last 5 ticks. Then a 2-tick high glitch -> no key_release.
// - Long press: hold key[1] low 30 ticks -> key_press[1] at debounce, key_long[1] once, 20 ticks later. Release -> key_release[1] after 5 high ticks.
// - Repeat (KEY_REPEAT_EN): hold 44 ticks beyond debounce -> key_long, then key_press every 8 ticks (3 repeat pulses). Without the macro: 0 repeats.
// - Simultaneous + reset: both keys pressed on the same clk -> both pulses in the same clk. Assert rst_n mid-HELD -> key_out=2'b11 immediately, no key_release.

Source files
------------

// File: rtl/key_debounce_multi.sv
// key_debounce_multi: N-channel active-low key debouncer with press, release
// and long-press event pulses. Each channel has a 2-FF synchroniser and a
// 4-state FSM (REL/PDB/HELD/RDB) that is advanced by a shared sample tick.
// Optional feature macro KEY_REPEAT_EN: when defined, a held key emits a
// key_press pulse every REPEAT_TICKS ticks once key_long has fired.
module key_debounce_multi #(
  parameter int N_KEYS       = 2,
  parameter int TICK_DIV     = 50000,
  parameter int DEB_CNT      = 5,
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 200
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key,
  output logic [N_KEYS-1:0] key_out,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long
);

  localparam int DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DCNT_W = $clog2(DEB_CNT + 1);
  localparam int HCNT_W = $clog2(LONG_TICKS + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [DCNT_W-1:0] DEB_MAX  = DCNT_W'(DEB_CNT);
  localparam logic [HCNT_W-1:0] HOLD_MAX = HCNT_W'(LONG_TICKS);

`ifdef KEY_REPEAT_EN
  localparam int RCNT_W = $clog2(REPEAT_TICKS + 1);
  localparam logic [RCNT_W-1:0] REP_MAX = RCNT_W'(REPEAT_TICKS);
`endif

  typedef enum logic [1:0] {REL, PDB, HELD, RDB} state_t;

  logic [N_KEYS-1:0] sync1;
  logic [N_KEYS-1:0] ks;
  logic [DIV_W-1:0]  div_q;
  logic              tick;

  // Two-stage synchroniser; preset to released so reset never looks like a press
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '1;
      ks    <= '1;
    end else begin
      sync1 <= key;
      ks    <= sync1;
    end
  end

  // Shared prescaler generating the one-clk sample tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
    end else if (tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  assign tick = (div_q == DIV_LAST);

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    state_t            state_q, state_d;
    logic [DCNT_W-1:0] dcnt_q, dcnt_d, dcnt_inc;
    logic [HCNT_W-1:0] hcnt_q, hcnt_d, hcnt_inc;
    logic              long_done;
    logic              press_d, release_d, long_d;
    logic              out_q, press_q, release_q, long_q;
`ifdef KEY_REPEAT_EN
    logic [RCNT_W-1:0] rcnt_q, rcnt_d, rcnt_inc;
    logic              rep_hit;

    assign rcnt_inc = rcnt_q + 1'b1;
    assign rep_hit  = (rcnt_inc == REP_MAX);
`endif

    assign dcnt_inc  = dcnt_q + 1'b1;
    assign hcnt_inc  = hcnt_q + 1'b1;
    assign long_done = (hcnt_q == HOLD_MAX);

    // State and counter register
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= REL;
        dcnt_q  <= '0;
        hcnt_q  <= '0;
`ifdef KEY_REPEAT_EN
        rcnt_q  <= '0;
`endif
      end else begin
        state_q <= state_d;
        dcnt_q  <= dcnt_d;
        hcnt_q  <= hcnt_d;
`ifdef KEY_REPEAT_EN
        rcnt_q  <= rcnt_d;
`endif
      end
    end

    // Next-state and counter update, evaluated only on the sample tick
    always_comb begin
      state_d = state_q;
      dcnt_d  = dcnt_q;
      hcnt_d  = hcnt_q;
`ifdef KEY_REPEAT_EN
      rcnt_d  = rcnt_q;
`endif
      if (tick) begin
        case (state_q)
          REL: begin
            if (!ks[i]) begin
              dcnt_d = DCNT_W'(1);
              if (DEB_CNT == 1) begin
                state_d = HELD;
                hcnt_d  = '0;
              end else begin
                state_d = PDB;
              end
            end
          end
          PDB: begin
            if (!ks[i]) begin
              dcnt_d = dcnt_inc;
              if (dcnt_inc == DEB_MAX) begin
                state_d = HELD;
                hcnt_d  = '0;
              end
            end else begin
              state_d = REL;
              dcnt_d  = '0;
            end
          end
          HELD: begin
            if (ks[i]) begin
              dcnt_d = DCNT_W'(1);
              if (DEB_CNT == 1) begin
                state_d = REL;
                hcnt_d  = '0;
`ifdef KEY_REPEAT_EN
                rcnt_d  = '0;
`endif
              end else begin
                state_d = RDB;
              end
            end else if (!long_done) begin
              hcnt_d = hcnt_inc;
            end else begin
`ifdef KEY_REPEAT_EN
              rcnt_d = rep_hit ? '0 : rcnt_inc;
`endif
            end
          end
          RDB: begin
            if (ks[i]) begin
              dcnt_d = dcnt_inc;
              if (dcnt_inc == DEB_MAX) begin
                state_d = REL;
                hcnt_d  = '0;
`ifdef KEY_REPEAT_EN
                rcnt_d  = '0;
`endif
              end
            end else begin
              state_d = HELD;
              dcnt_d  = '0;
            end
          end
          default: begin
            state_d = REL;
            dcnt_d  = '0;
          end
        endcase
      end
    end

    // Event decode: which pulse the current tick produces
    always_comb begin
      press_d   = 1'b0;
      release_d = 1'b0;
      long_d    = 1'b0;
      if (tick) begin
        case (state_q)
          REL:  press_d = !ks[i] && (DEB_CNT == 1);
          PDB:  press_d = !ks[i] && (dcnt_inc == DEB_MAX);
          HELD: begin
            if (ks[i]) begin
              release_d = (DEB_CNT == 1);
            end else begin
              long_d = !long_done && (hcnt_inc == HOLD_MAX);
`ifdef KEY_REPEAT_EN
              press_d = long_done && rep_hit;
`endif
            end
          end
          RDB:  release_d = ks[i] && (dcnt_inc == DEB_MAX);
          default: begin
            press_d = 1'b0;
          end
        endcase
      end
    end

    // Registered level and event pulses, one clk after the accepting tick
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_q     <= 1'b1;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
      end else begin
        out_q     <= !((state_d == HELD) || (state_d == RDB));
        press_q   <= press_d;
        release_q <= release_d;
        long_q    <= long_d;
      end
    end

    assign key_out[i]     = out_q;
    assign key_press[i]   = press_q;
    assign key_release[i] = release_q;
    assign key_long[i]    = long_q;
  end

endmodule

// File: tb/tb_key_debounce_multi.sv
// tb_key_debounce_multi: scoreboard bench for key_debounce_multi with a 4-clk
// tick, 5-tick debounce, 20-tick long press and 8-tick repeat. Expected events
// are queued as stimulus is applied and compared as the DUT pulses.
// Honours KEY_REPEAT_EN the same way the design does.
module tb_key_debounce_multi;

  localparam int N_KEYS       = 2;
  localparam int TICK_DIV     = 4;
  localparam int DEB_CNT      = 5;
  localparam int LONG_TICKS   = 20;
  localparam int REPEAT_TICKS = 8;

  localparam int EV_PRESS   = 0;
  localparam int EV_RELEASE = 1;
  localparam int EV_LONG    = 2;

  localparam int DEB_CLK  = DEB_CNT * TICK_DIV;
  localparam int LONG_CLK = LONG_TICKS * TICK_DIV;
  localparam int REP_CLK  = REPEAT_TICKS * TICK_DIV;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N_KEYS-1:0] key;
  logic [N_KEYS-1:0] key_out;
  logic [N_KEYS-1:0] key_press;
  logic [N_KEYS-1:0] key_release;
  logic [N_KEYS-1:0] key_long;

  int num_checks   = 0;
  int num_failures = 0;
  int cyc;
  int exp_q[$];

  key_debounce_multi #(
    .N_KEYS      (N_KEYS),
    .TICK_DIV    (TICK_DIV),
    .DEB_CNT     (DEB_CNT),
    .LONG_TICKS  (LONG_TICKS),
    .REPEAT_TICKS(REPEAT_TICKS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key        (key),
    .key_out    (key_out),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Edge counter since reset release; tick edges are the multiples of TICK_DIV
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    num_checks++;
    if (observed !== expected) begin
      num_failures++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic int evCode(input int at_cyc, input int ch, input int kind);
    return at_cyc * 16 + ch * 4 + kind;
  endfunction

  function automatic string kindName(input int kind);
    if (kind == EV_PRESS)   return "press_evt";
    if (kind == EV_RELEASE) return "release_evt";
    return "long_evt";
  endfunction

  task automatic pushEvt(input int at_cyc, input int ch, input int kind);
    exp_q.push_back(evCode(at_cyc, ch, kind));
  endtask

  // Drive a key level for a whole number of ticks; entered and left just after a tick edge
  task automatic applyStimulus(input logic [N_KEYS-1:0] lvl, input int ticks);
    key = lvl;
    repeat (ticks * TICK_DIV) @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every observed pulse must match the next expected event
  always @(negedge clk) begin
    if (rst_n) begin
      for (int ch = 0; ch < N_KEYS; ch++) begin
        for (int k = 0; k < 3; k++) begin
          logic [2:0] ev;
          ev = {key_long[ch], key_release[ch], key_press[ch]};
          if (ev[k]) begin
            if (exp_q.size() == 0) begin
              checkOutput("spurious_evt", evCode(cyc, ch, k), 32'hFFFF_FFFF);
            end else begin
              checkOutput(kindName(k), evCode(cyc, ch, k), exp_q.pop_front());
            end
          end
        end
      end
    end
  end

  initial begin
    int p;
    key   = 2'b00;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_key_out", key_out, 2'b11);
    checkOutput("rst_pulses", {key_press, key_release, key_long}, 6'b0);

    // Keys already low when reset releases: both press after 5 ticks
    rst_n = 1'b1;
    p = cyc;
    pushEvt(p + DEB_CLK, 0, EV_PRESS);
    pushEvt(p + DEB_CLK, 1, EV_PRESS);
    applyStimulus(2'b00, 4);
    checkOutput("pre_deb_out", key_out, 2'b11);
    applyStimulus(2'b00, 2);
    checkOutput("both_pressed", key_out, 2'b00);

    p = cyc;
    pushEvt(p + DEB_CLK, 0, EV_RELEASE);
    pushEvt(p + DEB_CLK, 1, EV_RELEASE);
    applyStimulus(2'b11, 6);
    checkOutput("both_released", key_out, 2'b11);

    // Clean press on key[0]; key[1] stays released
    p = cyc;
    pushEvt(p + DEB_CLK, 0, EV_PRESS);
    applyStimulus(2'b10, 10);
    checkOutput("clean_press_out", key_out, 2'b10);
    p = cyc;
    pushEvt(p + DEB_CLK, 0, EV_RELEASE);
    applyStimulus(2'b11, 6);
    checkOutput("clean_release_out", key_out, 2'b11);

    // Bounce: 3 low, 1 high, 5 low -> one press at the end of the final run
    p = cyc;
    pushEvt(p + (3 + 1) * TICK_DIV + DEB_CLK, 0, EV_PRESS);
    applyStimulus(2'b10, 3);
    applyStimulus(2'b11, 1);
    checkOutput("bounce_no_press", key_out, 2'b11);
    applyStimulus(2'b10, 5);
    // Two-tick release glitch must not release
    applyStimulus(2'b11, 2);
    applyStimulus(2'b10, 3);
    checkOutput("glitch_held_out", key_out, 2'b10);
    p = cyc;
    pushEvt(p + DEB_CLK, 0, EV_RELEASE);
    applyStimulus(2'b11, 6);

    // Long press on key[1]: 30 low ticks
    p = cyc;
    pushEvt(p + DEB_CLK, 1, EV_PRESS);
    pushEvt(p + DEB_CLK + LONG_CLK, 1, EV_LONG);
    applyStimulus(2'b01, 30);
    checkOutput("long_held_out", key_out, 2'b01);
    p = cyc;
    pushEvt(p + DEB_CLK, 1, EV_RELEASE);
    applyStimulus(2'b11, 6);
    checkOutput("long_release_out", key_out, 2'b11);

    // Hold key[0] 44 ticks beyond debounce: long, then repeats if enabled
    p = cyc;
    pushEvt(p + DEB_CLK, 0, EV_PRESS);
    pushEvt(p + DEB_CLK + LONG_CLK, 0, EV_LONG);
`ifdef KEY_REPEAT_EN
    for (int r = 1; r <= 3; r++) begin
      pushEvt(p + DEB_CLK + LONG_CLK + r * REP_CLK, 0, EV_PRESS);
    end
`endif
    applyStimulus(2'b10, 5 + 44);
    p = cyc;
    pushEvt(p + DEB_CLK, 0, EV_RELEASE);
    applyStimulus(2'b11, 6);

    // Simultaneous press, then reset while held: no release may follow
    p = cyc;
    pushEvt(p + DEB_CLK, 0, EV_PRESS);
    pushEvt(p + DEB_CLK, 1, EV_PRESS);
    applyStimulus(2'b00, 7);
    checkOutput("simul_held_out", key_out, 2'b00);
    rst_n = 1'b0;
    #1;
    checkOutput("midhold_rst_out", key_out, 2'b11);
    checkOutput("midhold_rst_pulses", {key_press, key_release, key_long}, 6'b0);
    key = 2'b11;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    checkOutput("post_rst_out", key_out, 2'b11);
    checkOutput("sb_drain", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", num_checks, num_failures);
    $finish;
  end

endmodule
